// File: rtl/nfu_1a_zskip_sched.sv
// Zero-skipping issue scheduler: per-lane oldest non-zero pick across a D+1 row window.
// Optional statistics counters are enabled with NFU1A_ZSKIP_STATS_EN.
module nfu_1a_zskip_sched #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int D         = 2,
    parameter int SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [BIT_WIDTH*Tn-1:0] i_in_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [BIT_WIDTH*Tn-1:0] o_out_data,
    output logic [SEL_WIDTH*Tn-1:0] o_out_sel,
    output logic [Tn-1:0]           o_out_lane_valid,
`ifdef NFU1A_ZSKIP_STATS_EN
    output logic [31:0]             o_stat_issues,
    output logic [31:0]             o_stat_zeros,
`endif
    output logic                    o_head_retired
);
    localparam int ROWS = D + 1;
    localparam int CW   = $clog2(ROWS + 1);
    localparam int ZW   = $clog2(ROWS * Tn + 1);

    logic [Tn-1:0][BIT_WIDTH-1:0] rowData     [ROWS];
    logic [Tn-1:0][BIT_WIDTH-1:0] rowDataNext [ROWS];
    logic [Tn-1:0]                pend        [ROWS];
    logic [Tn-1:0]                pendIss     [ROWS];
    logic [Tn-1:0]                pendNext    [ROWS];
    logic [ROWS-1:0]              rowValid, rowValidNext;
    logic [CW-1:0]                count, countNext, retireCnt, wIdx;
    logic [ZW-1:0]                zeroCnt;
    logic                         anyPend, issue, accept, headRun, found;
    logic [Tn-1:0][BIT_WIDTH-1:0] issData;
    logic [Tn-1:0][SEL_WIDTH-1:0] issSel;
    logic [Tn-1:0]                issLane;

    assign o_in_ready = (count < CW'(ROWS));
    assign accept     = i_in_valid && o_in_ready;

    always_comb begin
        anyPend = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            anyPend = anyPend | (|pend[r]);
            pendIss[r] = pend[r];
        end
        issue = anyPend && (!o_out_valid || i_out_ready);

        // Per-lane priority pick: lowest row wins, so lanes never reorder within a column.
        issData = '0;
        issSel  = '0;
        issLane = '0;
        for (int l = 0; l < Tn; l++) begin
            found = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                if (!found && pend[r][l]) begin
                    found      = 1'b1;
                    issData[l] = rowData[r][l];
                    issSel[l]  = SEL_WIDTH'(r);
                    issLane[l] = 1'b1;
                    if (issue) pendIss[r][l] = 1'b0;
                end
            end
        end

        retireCnt = '0;
        headRun   = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (headRun && rowValid[r] && (pendIss[r] == '0)) retireCnt = retireCnt + CW'(1);
            else headRun = 1'b0;
        end

        zeroCnt = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < Tn; l++) begin
                if ((CW'(r) < retireCnt) && (rowData[r][l] == '0)) zeroCnt = zeroCnt + ZW'(1);
            end
        end

        for (int r = 0; r < ROWS; r++) begin
            rowValidNext[r] = 1'b0;
            rowDataNext[r]  = '0;
            pendNext[r]     = '0;
            for (int s = 0; s < ROWS; s++) begin
                if (s == r + int'(retireCnt)) begin
                    rowValidNext[r] = rowValid[s];
                    rowDataNext[r]  = rowData[s];
                    pendNext[r]     = pendIss[s];
                end
            end
        end
        countNext = count - retireCnt;

        // New brick lands behind the post-retire tail.
        wIdx = count - retireCnt;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (CW'(r) == wIdx) begin
                    rowValidNext[r] = 1'b1;
                    rowDataNext[r]  = i_in_data;
                    for (int l = 0; l < Tn; l++) begin
                        pendNext[r][l] = (i_in_data[l*BIT_WIDTH +: BIT_WIDTH] != '0);
                    end
                end
            end
            countNext = countNext + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowValid <= '0;
            count    <= '0;
            for (int r = 0; r < ROWS; r++) begin
                rowData[r] <= '0;
                pend[r]    <= '0;
            end
        end else begin
            rowValid <= rowValidNext;
            count    <= countNext;
            for (int r = 0; r < ROWS; r++) begin
                rowData[r] <= rowDataNext[r];
                pend[r]    <= pendNext[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_out_valid      <= 1'b0;
            o_out_data       <= '0;
            o_out_sel        <= '0;
            o_out_lane_valid <= '0;
            o_head_retired   <= 1'b0;
        end else if (issue) begin
            o_out_valid      <= 1'b1;
            o_out_data       <= issData;
            o_out_sel        <= issSel;
            o_out_lane_valid <= issLane;
            o_head_retired   <= (retireCnt != '0);
        end else if (i_out_ready) begin
            o_out_valid    <= 1'b0;
            o_head_retired <= 1'b0;
        end
    end

`ifdef NFU1A_ZSKIP_STATS_EN
    logic [32:0] zeroSum;
    assign zeroSum = {1'b0, o_stat_zeros} + 33'(zeroCnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stat_issues <= '0;
            o_stat_zeros  <= '0;
        end else begin
            if (o_out_valid && i_out_ready && (o_stat_issues != '1)) o_stat_issues <= o_stat_issues + 32'd1;
            o_stat_zeros <= zeroSum[32] ? '1 : zeroSum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_nfu_1a_zskip_sched.sv
// Directed bench for nfu_1a_zskip_sched: reset, dense, lookahead, zero-skip, backpressure, full-window.
module tb_nfu_1a_zskip_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [255:0] i_in_data = '0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [255:0] o_out_data;
    logic [31:0]  o_out_sel;
    logic [15:0]  o_out_lane_valid;
    logic         o_head_retired;
`ifdef NFU1A_ZSKIP_STATS_EN
    logic [31:0]  o_stat_issues;
    logic [31:0]  o_stat_zeros;
    logic [31:0]  zerosBefore;
`endif

    int nChecks = 0;
    int nPass   = 0;

    nfu_1a_zskip_sched dut (
        .clk(clk), .rst(rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_data(o_out_data), .o_out_sel(o_out_sel),
        .o_out_lane_valid(o_out_lane_valid),
`ifdef NFU1A_ZSKIP_STATS_EN
        .o_stat_issues(o_stat_issues), .o_stat_zeros(o_stat_zeros),
`endif
        .o_head_retired(o_head_retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, expv);
    endtask

    task automatic chkSlot(input string tag, input logic [255:0] expData, input logic [31:0] expSel,
                           input logic [15:0] expMask, input logic expHead);
        chk({tag, ".valid"}, 256'(o_out_valid), 256'(1'b1));
        chk({tag, ".data"}, o_out_data, expData);
        chk({tag, ".sel"}, 256'(o_out_sel), 256'(expSel));
        chk({tag, ".mask"}, 256'(o_out_lane_valid), 256'(expMask));
        chk({tag, ".head"}, 256'(o_head_retired), 256'(expHead));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.valid", 256'(o_out_valid), 256'(1'b0));
        chk("rst.ready", 256'(o_in_ready), 256'(1'b1));

        // Mid-stream reset with three bricks buffered and one slot held
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = {16{16'h0007}};
        repeat (4) step();
        i_in_valid = 1'b0;
        chk("pre_rst.valid", 256'(o_out_valid), 256'(1'b1));
        chk("pre_rst.inready", 256'(o_in_ready), 256'(1'b0));
        rst = 1'b1;
        #1;
        chk("async_rst.valid", 256'(o_out_valid), 256'(1'b0));
        chk("async_rst.data", o_out_data, 256'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst.inready", 256'(o_in_ready), 256'(1'b1));
        i_out_ready = 1'b1;
        step();
        step();
        chk("post_rst.nostale", 256'(o_out_valid), 256'(1'b0));
        i_in_valid = 1'b1;
        i_in_data  = {16{16'h0001}};
        step();
        i_in_valid = 1'b0;
        chk("post_rst.latency", 256'(o_out_valid), 256'(1'b0));
        step();
        chkSlot("post_rst.slot", {16{16'h0001}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chk("post_rst.drop", 256'(o_out_valid), 256'(1'b0));

        // Dense stream
        i_in_valid = 1'b1;
        i_in_data  = {16{16'h1000}};
        step();
        chk("dense.latency", 256'(o_out_valid), 256'(1'b0));
        i_in_data = {16{16'h1001}};
        step();
        chkSlot("dense.s0", {16{16'h1000}}, 32'h0, 16'hFFFF, 1'b1);
        i_in_data = {16{16'h1002}};
        step();
        chkSlot("dense.s1", {16{16'h1001}}, 32'h0, 16'hFFFF, 1'b1);
        i_in_data = {16{16'h1003}};
        step();
        chkSlot("dense.s2", {16{16'h1002}}, 32'h0, 16'hFFFF, 1'b1);
        i_in_valid = 1'b0;
        step();
        chkSlot("dense.s3", {16{16'h1003}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chk("dense.drop", 256'(o_out_valid), 256'(1'b0));

        // Lookahead: park a slot, load B0..B2 behind it, then release
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = {16{16'h0001}};
        step();
        i_in_data = {240'h0, 16'h0005};
        step();
        i_in_data = {224'h0, 16'h0009, 16'h0007};
        step();
        i_in_data = {224'h0, 16'h000B, 16'h0000};
        step();
        i_in_valid = 1'b0;
        chk("look.full", 256'(o_in_ready), 256'(1'b0));
        chk("look.park", o_out_data, {16{16'h0001}});
        i_out_ready = 1'b1;
        step();
        chkSlot("look.s1", {224'h0, 16'h0009, 16'h0005}, 32'h4, 16'h0003, 1'b1);
        step();
        chkSlot("look.s2", {224'h0, 16'h000B, 16'h0007}, 32'h4, 16'h0003, 1'b1);
        step();
        chk("look.drop", 256'(o_out_valid), 256'(1'b0));

        // All-zero bricks drain without slots
`ifdef NFU1A_ZSKIP_STATS_EN
        zerosBefore = o_stat_zeros;
`endif
        i_in_valid = 1'b1;
        i_in_data  = '0;
        step();
        step();
        i_in_data = {16{16'h0003}};
        step();
        i_in_valid = 1'b0;
        chk("zero.noslot", 256'(o_out_valid), 256'(1'b0));
        step();
        chkSlot("zero.slot", {16{16'h0003}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chk("zero.drop", 256'(o_out_valid), 256'(1'b0));
`ifdef NFU1A_ZSKIP_STATS_EN
        chk("zero.stat", 256'(o_stat_zeros - zerosBefore), 256'd32);
`endif

        // Backpressure
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = {16{16'h0200}};
        step();
        i_in_data = {16{16'h0201}};
        step();
        chkSlot("bp.s0", {16{16'h0200}}, 32'h0, 16'hFFFF, 1'b1);
        i_in_data = {16{16'h0202}};
        step();
        chk("bp.ready2", 256'(o_in_ready), 256'(1'b1));
        i_in_data = {16{16'h0203}};
        step();
        chk("bp.ready_fall", 256'(o_in_ready), 256'(1'b0));
        i_in_data = {16{16'h0204}};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_valid", 256'(o_out_valid), 256'(1'b1));
            chk("bp.hold_data", o_out_data, {16{16'h0200}});
            chk("bp.hold_ready", 256'(o_in_ready), 256'(1'b0));
        end
        i_out_ready = 1'b1;
        step();
        chkSlot("bp.s1", {16{16'h0201}}, 32'h0, 16'hFFFF, 1'b1);
        chk("bp.ready_back", 256'(o_in_ready), 256'(1'b1));
        step();
        i_in_valid = 1'b0;
        chkSlot("bp.s2", {16{16'h0202}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chkSlot("bp.s3", {16{16'h0203}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chkSlot("bp.s4", {16{16'h0204}}, 32'h0, 16'hFFFF, 1'b1);
        step();
        chk("bp.drop", 256'(o_out_valid), 256'(1'b0));

        // Full window: retire and offer on the same edge, then land in row D
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = {16{16'h0001}};
        step();
        i_in_data = {16{16'h0010}};
        step();
        i_in_data = {240'h0, 16'h0021};
        step();
        i_in_data = {240'h0, 16'h0022};
        step();
        chk("full.park", o_out_data, {16{16'h0001}});
        chk("full.notready", 256'(o_in_ready), 256'(1'b0));
        i_in_data   = {224'h0, 16'h0033, 16'h0000};
        i_out_ready = 1'b1;
        step();
        chkSlot("full.f0", {16{16'h0010}}, 32'h0, 16'hFFFF, 1'b1);
        chk("full.ready_after", 256'(o_in_ready), 256'(1'b1));
        i_out_ready = 1'b0;
        step();
        i_in_valid = 1'b0;
        chk("full.accepted", 256'(o_in_ready), 256'(1'b0));
        chk("full.hold", o_out_data, {16{16'h0010}});
        i_out_ready = 1'b1;
        step();
        chkSlot("full.s1", {224'h0, 16'h0033, 16'h0021}, 32'h8, 16'h0003, 1'b1);
        step();
        chkSlot("full.s2", {240'h0, 16'h0022}, 32'h0, 16'h0001, 1'b1);
        step();
        chk("full.drop", 256'(o_out_valid), 256'(1'b0));
        chk("full.empty", 256'(o_in_ready), 256'(1'b1));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/nfu_1a_zskip_sched.md
Name: nfu_1a_zskip_sched

Overview:
- Sequential successor to the combinational NFU-1A replacement-candidate muxing.
- Buffers a lookahead window of D+1 input bricks, each of Tn neurons.
- Every issue cycle, each lane independently sends NFU-1B the oldest still-pending non-zero value in its window column, together with the row offset it came from.
- Zero values are never issued. All-zero bricks retire without consuming an issue cycle.

Parameters:
- BIT_WIDTH, 16, width of one neuron value.
- Tn, 16, lanes per brick.
- D, 2, lookahead depth; the window holds D+1 rows (row 0 is the head).
- SEL_WIDTH, 2, offset field width; must satisfy 2^SEL_WIDTH >= D+1.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- i_in_valid  input  1  brick present on i_in_data.
- o_in_ready  output  1  window can accept a brick.
- i_in_data  input  BIT_WIDTH*Tn  brick; lane l occupies [(l+1)*BIT_WIDTH-1 : l*BIT_WIDTH].
- o_out_valid  output  1  issue slot valid.
- i_out_ready  input  1  NFU-1B accepts the slot.
- o_out_data  output  BIT_WIDTH*Tn  selected value per lane.
- o_out_sel  output  SEL_WIDTH*Tn  per-lane row offset (0..D) of the value.
- o_out_lane_valid  output  Tn  lane carries a non-zero value.
- o_head_retired  output  1  at least one head row retired on this issue.

Behaviour:
- State per row r (0..D):
  - row_valid[r];
  - Tn values;
  - pend[r][l] = row valid AND value non-zero AND not yet issued.
  - count = number of valid rows; valid rows are always contiguous from row 0.
- Reset (async): all row_valid=0, pend=0, count=0. o_out_valid=0, o_out_data=0, o_out_sel=0, o_out_lane_valid=0, o_head_retired=0. Reset mid-operation discards all buffered bricks and any pending output.
- o_in_ready = (count < D+1), combinational from registered count. It does not anticipate retirement in the same cycle.
- Accept: on i_in_valid & o_in_ready, the brick is written to row (count - retired_this_cycle), with pend = per-lane non-zero.
- Issue enable: any pend bit set in rows 0..D AND (!o_out_valid | i_out_ready).
- Issue, per lane l:
  - Pick the smallest r with pend[r][l]=1.
  - Register value, sel=r, lane_valid=1, and clear pend[r][l].
  - Lanes with no pending bit get data=0, sel=0, lane_valid=0.
  - Register o_out_valid=1.
- Without issue:
  - If i_out_ready, o_out_valid -> 0.
  - Else outputs hold stable: valid/data/sel/mask unchanged while stalled.
- Retire:
  - After the issue update, let k = length of the leading run of valid rows with pend all zero.
  - Shift the window down by k in the same edge; count -= k.
  - o_head_retired=1 registered with the issue slot if k>0.
  - Retirement also happens on non-issue cycles, so all-zero bricks drain with no output slot.
- Latency: a brick accepted at edge t can appear on o_out_* after edge t+1.
- Ordering: within a lane, values issue in brick order. Lanes may lead the head by at most D rows.
- Simultaneous accept and retire in one cycle is legal. The write index uses post-retire count.
- Full window with head blocked: o_in_ready=0 until retirement.
- Empty window: o_out_valid drops once the last slot is accepted.

Optional Feature:
- Macro NFU1A_ZSKIP_STATS_EN.
- When defined, adds output o_stat_issues (32b) = number of accepted issue slots (o_out_valid & i_out_ready).
- Adds output o_stat_zeros (32b) = number of zero values retired without issue.
- Both counters reset to 0 and saturate at 2^32-1.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst mid-stream with 3 bricks buffered -> after release: o_out_valid=0, o_in_ready=1, no stale data issued; an input of all lanes=0x0001 gives one slot with mask 0xFFFF, sel all 0.
- Dense stream: 4 bricks, all lanes non-zero, i_out_ready=1 -> 4 slots on consecutive cycles, sel=0 everywhere, o_head_retired=1 on each; first slot one cycle after first accept.
- Lookahead (Tn=16, D=2):
  - Bricks: B0 = lane0 only 0x0005; B1 = lane0 0x0007 plus lane1 0x0009; B2 = lane1 0x000B.
  - Required slot 1: lane0=5/sel0, lane1=9/sel1.
  - Required slot 2: lane0=7/sel0 (B1 now head), lane1=0xB/sel1.
  - Total 2 slots.
- All-zero bricks: B0 = 0, B1 = 0, B2 = all lanes 0x0003 -> exactly one slot, sel=0 on all lanes, o_head_retired=1. o_stat_zeros=32 when NFU1A_ZSKIP_STATS_EN is defined.
- Backpressure: hold i_out_ready=0 for 5 cycles during a stream -> outputs stable; o_in_ready falls after D+1=3 accepts; resumes with no loss or duplication.
- Simultaneous accept and retire: window full, head retires on the same edge a new brick is offered with i_in_valid=1 -> brick not accepted that cycle (o_in_ready=0), accepted next cycle into row D.
